jtdd_obj_linebuf: RTL



---
 rtl/jtdd_pkg.sv | 12 +
 rtl/jtdd_obj_lbuf_bank.sv | 53 +++++
 rtl/jtdd_obj_linebuf.sv | 108 ++++++++++
 3 files changed

// File: rtl/jtdd_pkg.sv
// Shared definitions for the object line buffer: state encoding and the
// transparent pixel code.
package jtdd_pkg;

  typedef enum logic {
    ST_CLR = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  localparam logic [3:0] TRANSP_CODE = 4'h0;

endpackage

// File: rtl/jtdd_obj_lbuf_bank.sv
// One line-buffer bank: dual-port RAM with a port-0 mux that picks between
// the clear sweep, the post-read erase and the drawer.
module jtdd_obj_lbuf_bank
  import jtdd_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          bank_id,
  input  logic          sel,
  input  logic          clr,
  input  logic [AW-1:0] clr_addr,
  input  logic          erase,
  input  logic [AW-1:0] rd_addr,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic          is_wr;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_data;

  // Erase only targets the read bank and the drawer only the write bank,
  // so at most one of them is ever asking for this port.
  always_comb begin
    is_wr   = (bank_id == sel);
    p0_we   = 1'b0;
    p0_addr = wr_addr;
    p0_data = '0;
    if (clr) begin
      p0_we   = 1'b1;
      p0_addr = clr_addr;
    end else if (erase && !is_wr) begin
      p0_we   = 1'b1;
      p0_addr = rd_addr;
    end else if (we && is_wr && (wr_data[3:0] != TRANSP_CODE)) begin
      p0_we   = 1'b1;
      p0_data = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (p0_we) mem[p0_addr] <= p0_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/jtdd_obj_linebuf.sv
// Double-buffered object line buffer: drawer fills bank sel while bank ~sel
// is read out at pixel rate and erased behind the read pointer.
module jtdd_obj_linebuf
  import jtdd_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          flip,
  input  logic [AW-1:0] hdump,
  input  logic          buf_we,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  output logic          busy,
  output logic [DW-1:0] obj_pxl
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          sel_q, sel_d;
  logic          lhbl_l_q, lhbl_l_d;
  logic          erase_q, erase_d;
  logic [DW-1:0] obj_pxl_q, obj_pxl_d;
  logic [DW-1:0] rd_data0, rd_data1, rd_data;
  logic          clr;

  assign clr     = (state_q == ST_CLR);
  assign busy    = clr;
  assign obj_pxl = obj_pxl_q;
  assign rd_data = sel_q ? rd_data0 : rd_data1;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rd_addr_d = rd_addr_q;
    sel_d     = sel_q;
    lhbl_l_d  = LHBL;
    erase_d   = 1'b0;
    obj_pxl_d = obj_pxl_q;
    if (clr) begin
      clr_cnt_d = clr_cnt_q + ONE;
      if (&clr_cnt_q) state_d = ST_RUN;
    end else begin
      if (lhbl_l_q && !LHBL) sel_d = ~sel_q;
      if (pxl_cen) begin
        rd_addr_d = flip ? ~hdump : hdump;
        obj_pxl_d = LHBL ? rd_data : '0;
        erase_d   = LHBL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLR;
      clr_cnt_q <= '0;
      rd_addr_q <= '0;
      sel_q     <= 1'b0;
      lhbl_l_q  <= 1'b1;
      erase_q   <= 1'b0;
      obj_pxl_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rd_addr_q <= rd_addr_d;
      sel_q     <= sel_d;
      lhbl_l_q  <= lhbl_l_d;
      erase_q   <= erase_d;
      obj_pxl_q <= obj_pxl_d;
    end
  end

  jtdd_obj_lbuf_bank #(.AW(AW), .DW(DW)) u_bank0 (
    .clk      (clk),
    .bank_id  (1'b0),
    .sel      (sel_q),
    .clr      (clr),
    .clr_addr (clr_cnt_q),
    .erase    (erase_q),
    .rd_addr  (rd_addr_q),
    .we       (buf_we),
    .wr_addr  (buf_addr),
    .wr_data  (buf_data),
    .rd_data  (rd_data0)
  );

  jtdd_obj_lbuf_bank #(.AW(AW), .DW(DW)) u_bank1 (
    .clk      (clk),
    .bank_id  (1'b1),
    .sel      (sel_q),
    .clr      (clr),
    .clr_addr (clr_cnt_q),
    .erase    (erase_q),
    .rd_addr  (rd_addr_q),
    .we       (buf_we),
    .wr_addr  (buf_addr),
    .wr_data  (buf_data),
    .rd_data  (rd_data1)
  );

endmodule
